// File: rtl/sseg_scan_driver.sv
// Multiplexed hex seven-segment scan driver with frame-synchronous (tear-free) display updates.
// Define SSEG_LZB_EN to blank leading zero digits (digit 0 is always shown).
module sseg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  wrap;
    logic [4*DIGITS-1:0]   disp_val;
    logic [DIGITS-1:0]     disp_dp;
    logic [4*DIGITS-1:0]   pend_val;
    logic [DIGITS-1:0]     pend_dp;
    logic                  pend_valid;
    logic [3:0]            nib;
    logic                  nib_dp;
    logic                  blank;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick       = (cnt == CNT_LAST);
    assign wrap       = tick && (idx == IDX_LAST);
    assign frame_done = wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // The display register only changes on the wrap tick, so a frame is never torn.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_val   <= '0;
            disp_dp    <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (wrap) begin
            if (load) begin
                disp_val <= value;
                disp_dp  <= dp_in;
            end else if (pend_valid) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_val   <= value;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
        end
    end

    assign nib    = disp_val[{idx, 2'b00} +: 4];
    assign nib_dp = disp_dp[idx];

`ifdef SSEG_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              zero_above;

    // Scan from the top digit down; a digit is leading-zero while everything above it is zero.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (disp_val[4*i +: 4] == 4'h0);
            lz[i]      = zero_above;
        end
    end

    assign blank = lz[idx];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an  <= '0;
            seg <= 7'h00;
            dp  <= 1'b0;
        end else begin
            an  <= AN_ONE << idx;
            seg <= blank ? 7'h00 : enc(nib);
            dp  <= nib_dp;
        end
    end
endmodule

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of multiplexed hex digits (1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles each digit is held (>=2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port value, input, 4*DIGITS, meaning hex nibbles; nibble i drives digit i, with digit 0 = bits [3:0].
REQ-006 SHALL have port dp_in, input, DIGITS, meaning decimal point request per digit.
REQ-007 SHALL have port load, input, 1, meaning single-cycle strobe that captures value and dp_in.
REQ-008 SHALL have port seg, output, 7, meaning segments {g,f,e,d,c,b,a}, with 1 = lit.
REQ-009 SHALL have port dp, output, 1, meaning decimal point of the active digit, with 1 = lit.
REQ-010 SHALL have port an, output, DIGITS, meaning one-hot digit enable, with 1 = digit on.
REQ-011 SHALL have port frame_done, output, 1, meaning one-cycle pulse at end of each full scan.

Function
REQ-012 SHALL encode nibbles as 0-F -> 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex); blank = 00.
REQ-013 SHALL run prescaler 0..SCAN_DIV-1; terminal count = "tick", prescaler wraps to 0.
REQ-014 SHALL advance digit index on tick: i -> i+1, DIGITS-1 -> 0 (wrap).
REQ-015 SHALL assert frame_done for exactly the tick cycle on which index wraps DIGITS-1 -> 0.
REQ-016 SHALL on load capture value/dp_in into a pending register and set pending_valid.
REQ-017 SHALL on wrap tick with pending_valid copy pending to display register and clear pending_valid.
REQ-018 SHALL on load coincident with wrap tick copy the newly loaded value directly to display and leave pending_valid clear.
REQ-019 SHALL on load while pending_valid replace pending (last load wins); display SHALL never change mid-frame.
REQ-020 SHALL register seg/dp/an: outputs reflect index and display register one cycle after they change.
REQ-021 SHALL drive an one-hot at index, and seg/dp from display nibble/bit at index, every cycle after reset.
REQ-022 SHALL support DIGITS=1 (index constant 0; frame_done pulses every tick).

Reset
REQ-023 SHALL on reset_n low asynchronously force an=0, seg=00, dp=0, frame_done=0.
REQ-024 SHALL on reset_n low clear prescaler, index, display, pending, pending_valid to 0.
REQ-025 SHALL on first edge after release drive an[0]=1, seg=3F (display=0), prescaler counting from 0.
REQ-026 SHALL on reset mid-frame discard pending data; no partial frame resumes.

Configuration
REQ-027 SHALL implement leading-zero blanking under macro SSEG_LZB_EN.
REQ-028 SHALL with SSEG_LZB_EN define digit i as a leading zero when digits i..DIGITS-1 of display are all 0 and i>0; such digit SHALL output seg=00, dp=dp bit, an bit still asserted.
REQ-029 SHALL with SSEG_LZB_EN always display digit 0 (value 0 shows 3F on digit 0).
REQ-030 SHALL without SSEG_LZB_EN display every digit, including leading zeros as 3F.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-031 SHALL cover reset: reset_n=0 mid-scan -> same instant an=0000, seg=00, dp=0, frame_done=0.
REQ-032 SHALL cover scan: load 16'h12AF, dp_in=0 -> after next wrap: an=0001/seg=71, an=0010/77, an=0100/5B, an=1000/06, each held 4 cycles.
REQ-033 SHALL cover frame: free run -> frame_done high 1 cycle every 16 cycles, coincident with index 3->0.
REQ-034 SHALL cover no tearing: load 16'h1111 then 16'h2222 mid-frame -> current frame unchanged; next frame shows all 5B; 06 never shown.
REQ-035 SHALL cover coincident load/wrap: load 16'h4444 on wrap tick -> next frame all 66.
REQ-036 SHALL cover LZB: load 16'h0042, dp_in=4'b0100 -> with SSEG_LZB_EN digit3 seg=00, digit2 seg=00 with dp=1, digit1 66, digit0 5B; without macro digits 3,2 = 3F.
